sensor_uart_formatter: RTL and testbench
========================================

Name: sensor_uart_formatter

Overview:
- Converts ultrasonic distance results and DHT11 humidity/temperature results into ASCII text frames for the UART transmitter.
- Sits between the sensor blocks (distance result + done, DHT result + done) and the UART TX FIFO push interface.
- Latches both event types independently and serialises them one byte per cycle under TX back-pressure.
- Binary-to-decimal conversion is sequential (double-dabble), so no wide combinational dividers are used.

Parameters:
- DIST_W, 10, width of distance input in cm; 4 decimal digits are printed, and values >9999 saturate to 9999.
- SAT_INT, 99, saturation value for the humidity and temperature integer parts (2 digits printed).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- i_dist_data  input  DIST_W  distance in cm; valid in the cycle dist_done=1
- dist_done  input  1  one-cycle pulse, new distance
- i_dht_data  input  32  [31:24] RH int, [23:16] RH dec, [15:8] T int, [7:0] T dec; valid with dht_done
- dht_done  input  1  one-cycle pulse, new DHT result
- tx_full  input  1  TX FIFO full; no push is allowed while high
- tx_data  output  8  ASCII byte
- tx_push  output  1  one-cycle write strobe, never asserted while tx_full=1
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse after the last byte of a frame is pushed
- ovr_cnt  output  8  saturating count of overwritten pending events

Behaviour:
- Reset values: tx_data=0, tx_push=0, busy=0, frame_done=0, ovr_cnt=0, pending flags/buffers cleared, state=IDLE.
- Capture:
  - A done pulse copies its data into that type's pending buffer and sets its pending flag, in every state.
  - If the flag is already set, the data is overwritten and ovr_cnt increments, saturating at 255.
- Frame formats:
  - Distance frame is 8 bytes: "D=dddd" CR LF, for example 123 gives "D=0123\r\n".
  - DHT frame is 16 bytes: "H=ii.d%T=ii.dC" CR LF.
  - Integer parts above SAT_INT print as 99.
  - Decimal bytes above 9 print as 9.
  - Digits are ASCII 0x30+digit.
- States:
  - IDLE:
    - If the dist flag is set, go to LOAD with sel=DIST.
    - Otherwise, if the dht flag is set, go to LOAD with sel=DHT.
    - Distance has priority when both flags are set.
  - LOAD (1 cycle):
    - Move the selected pending buffer into the working register.
    - Clear its flag. A done pulse of the same type in this same cycle sets the flag again and is not counted as an overrun.
  - CONV:
    - Double-dabble, one shift per cycle.
    - Distance takes DIST_W cycles.
    - DHT takes 8 cycles, converting RH-int and T-int in parallel.
  - SEND:
    - Byte index starts at 0.
    - Each cycle with tx_full=0: drive tx_data=frame[idx], pulse tx_push, increment idx.
    - Each cycle with tx_full=1: hold idx and tx_push=0.
    - After the last byte, go to FIN.
  - FIN (1 cycle):
    - Pulse frame_done.
    - Return to IDLE.
- Latency: first tx_push occurs exactly 2+DIST_W cycles (distance) or 10 cycles (DHT) after the cycle the done pulse is sampled in IDLE, provided tx_full=0.
- Throughput: minimum frame spacing equals frame length + conversion + 3 cycles.
- Mid-frame events: new done pulses do not disturb the current frame. They are served next, in priority order.
- Reset mid-operation: the current frame is aborted immediately, tx_push drops the next cycle, and no partial resumption occurs.
- tx_full toggling every cycle: bytes still arrive in order, with no duplicates and no gaps.

Optional Feature:
- Macro FMT_CHECKSUM_EN.
- Defined:
  - Insert "*" followed by 2 uppercase hex digits before CR LF.
  - The checksum is the XOR of all preceding frame bytes, starting at the first character.
  - Distance frame becomes 11 bytes; DHT frame becomes 19 bytes.
- Undefined: frames exactly as above; no checksum logic is synthesised.

Test Plan:
- dist_done with 123, tx_full=0 -> first push 12 cycles later; bytes 44 3D 30 31 32 33 0D 0A; frame_done 1 cycle after 0x0A.
- dht_done with 0x2D00_1705 -> "H=45.0%T=23.5C\r\n"; with 0x7F0C_6400 -> "H=99.9%T=99.0C\r\n".
- dist_done and dht_done in the same cycle with values 400 and 0x3200_1400 -> "D=0400\r\n" fully, then "H=50.0%T=20.0C\r\n"; ovr_cnt=0.
- Three dist_done pulses during an ongoing DHT frame -> only the last distance is sent; ovr_cnt=2.
- tx_full held high 5 cycles mid-frame, then toggled every cycle -> no tx_push while full; byte sequence intact.
- rst pulsed during SEND byte 3 -> outputs at reset values the next cycle; no further pushes; a new dist_done yields a complete frame. With FMT_CHECKSUM_EN, "D=0123" is followed by "*" then the 2 hex digits of its XOR checksum, then CR LF.

Source files
------------

// File: rtl/sensor_uart_formatter.sv
// Formats ultrasonic distance and DHT11 results as ASCII UART frames, one byte per cycle.
// Optional macro FMT_CHECKSUM_EN appends "*HH" (XOR checksum of the payload, uppercase hex) before CR LF.
module sensor_uart_formatter #(
  parameter int DIST_W  = 10,
  parameter int SAT_INT = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] i_dist_data,
  input  logic              dist_done,
  input  logic [31:0]       i_dht_data,
  input  logic              dht_done,
  input  logic              tx_full,
  output logic [7:0]        tx_data,
  output logic              tx_push,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        ovr_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_SEND, S_FIN} state_t;

  localparam logic [4:0] DIST_PAY = 5'd6;
  localparam logic [4:0] DHT_PAY  = 5'd14;
`ifdef FMT_CHECKSUM_EN
  localparam logic [4:0] TAIL_LEN = 5'd5;
`else
  localparam logic [4:0] TAIL_LEN = 5'd2;
`endif

  function automatic logic [DIST_W-1:0] sat_dist(input logic [DIST_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    if (w > 32'd9999) w = 32'd9999;
    return w[DIST_W-1:0];
  endfunction

  function automatic logic [7:0] sat_int(input logic [7:0] v);
    if ((int'(v) > SAT_INT) || (v > 8'd99)) return 8'd99;
    return v;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [7:0] v);
    return (v > 8'd9) ? 4'd9 : v[3:0];
  endfunction

  function automatic logic [15:0] adj16(input logic [15:0] b);
    for (int i = 0; i < 4; i++)
      if (b[i*4 +: 4] >= 4'd5) b[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return b;
  endfunction

  function automatic logic [7:0] adj8(input logic [7:0] b);
    for (int i = 0; i < 2; i++)
      if (b[i*4 +: 4] >= 4'd5) b[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return b;
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

`ifdef FMT_CHECKSUM_EN
  function automatic logic [7:0] hexc(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction
`endif

  state_t            r_state, w_next;
  logic              r_sel, w_sel_next;          // 0 = distance, 1 = DHT
  logic [5:0]        r_cnt;
  logic [4:0]        r_idx;
  logic              r_dist_pend, r_dht_pend;
  logic [DIST_W-1:0] r_dist_buf;
  logic [31:0]       r_dht_buf;
  logic [7:0]        r_ovr;

  logic [DIST_W-1:0] r_dbin;
  logic [15:0]       r_dbcd;
  logic [7:0]        r_hbin, r_tbin, r_hbcd, r_tbcd;
  logic [3:0]        r_hdec, r_tdec;
`ifdef FMT_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_dist_clr, w_dht_clr;
  logic [1:0]        w_ovr_inc;
  logic [8:0]        w_ovr_sum;
  logic [4:0]        w_pay, w_rel, w_last;
  logic [7:0]        w_byte;

  assign w_dist_clr = (r_state == S_LOAD) && !r_sel;
  assign w_dht_clr  = (r_state == S_LOAD) &&  r_sel;
  // A done pulse in the LOAD cycle of its own type re-arms the flag without counting as an overrun.
  assign w_ovr_inc  = {1'b0, dist_done && r_dist_pend && !w_dist_clr}
                    + {1'b0, dht_done  && r_dht_pend  && !w_dht_clr};
  assign w_ovr_sum  = {1'b0, r_ovr} + {7'd0, w_ovr_inc};

  assign w_pay  = r_sel ? DHT_PAY : DIST_PAY;
  assign w_last = w_pay + TAIL_LEN - 5'd1;
  assign w_rel  = r_idx - w_pay;

  always_comb begin
    w_next     = r_state;
    w_sel_next = r_sel;
    case (r_state)
      S_IDLE: begin
        if (r_dist_pend || dist_done) begin
          w_next     = S_LOAD;
          w_sel_next = 1'b0;
        end else if (r_dht_pend || dht_done) begin
          w_next     = S_LOAD;
          w_sel_next = 1'b1;
        end
      end
      S_LOAD:  w_next = S_CONV;
      S_CONV:  if (r_cnt == 6'd0) w_next = S_SEND;
      S_SEND:  if (!tx_full && (r_idx == w_last)) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_cnt       <= 6'd0;
      r_idx       <= 5'd0;
      r_dist_pend <= 1'b0;
      r_dht_pend  <= 1'b0;
      r_dist_buf  <= '0;
      r_dht_buf   <= '0;
      r_ovr       <= 8'd0;
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel_next;
      case (r_state)
        S_LOAD: r_cnt <= r_sel ? 6'd7 : 6'(DIST_W - 1);
        S_CONV: begin
          r_cnt <= r_cnt - 6'd1;
          r_idx <= 5'd0;
        end
        S_SEND: if (!tx_full) r_idx <= r_idx + 5'd1;
        default: ;
      endcase
      if (dist_done) begin
        r_dist_buf  <= sat_dist(i_dist_data);
        r_dist_pend <= 1'b1;
      end else if (w_dist_clr) begin
        r_dist_pend <= 1'b0;
      end
      if (dht_done) begin
        r_dht_buf  <= i_dht_data;
        r_dht_pend <= 1'b1;
      end else if (w_dht_clr) begin
        r_dht_pend <= 1'b0;
      end
      r_ovr <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
    end
  end

  // LOAD -> CONV: saturate into working registers, then one double-dabble shift per cycle
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      if (!r_sel) begin
        r_dbin <= r_dist_buf;
        r_dbcd <= 16'd0;
      end else begin
        r_hbin <= sat_int(r_dht_buf[31:24]);
        r_tbin <= sat_int(r_dht_buf[15:8]);
        r_hdec <= sat_dec(r_dht_buf[23:16]);
        r_tdec <= sat_dec(r_dht_buf[7:0]);
        r_hbcd <= 8'd0;
        r_tbcd <= 8'd0;
      end
    end else if (r_state == S_CONV) begin
      if (!r_sel) begin
        {r_dbcd, r_dbin} <= {adj16(r_dbcd), r_dbin} << 1;
      end else begin
        {r_hbcd, r_hbin} <= {adj8(r_hbcd), r_hbin} << 1;
        {r_tbcd, r_tbin} <= {adj8(r_tbcd), r_tbin} << 1;
      end
    end
  end

`ifdef FMT_CHECKSUM_EN
  // Running XOR over payload bytes only; the '*' and hex digits are excluded.
  always_ff @(posedge clk) begin
    if (r_state == S_CONV) r_csum <= 8'd0;
    else if (tx_push && (r_idx < w_pay)) r_csum <= r_csum ^ w_byte;
  end
`endif

  always_comb begin
    w_byte = 8'h00;
    if (r_idx < w_pay) begin
      if (!r_sel) begin
        case (r_idx)
          5'd0:    w_byte = "D";
          5'd1:    w_byte = "=";
          5'd2:    w_byte = asc(r_dbcd[15:12]);
          5'd3:    w_byte = asc(r_dbcd[11:8]);
          5'd4:    w_byte = asc(r_dbcd[7:4]);
          default: w_byte = asc(r_dbcd[3:0]);
        endcase
      end else begin
        case (r_idx)
          5'd0:    w_byte = "H";
          5'd1:    w_byte = "=";
          5'd2:    w_byte = asc(r_hbcd[7:4]);
          5'd3:    w_byte = asc(r_hbcd[3:0]);
          5'd4:    w_byte = ".";
          5'd5:    w_byte = asc(r_hdec);
          5'd6:    w_byte = "%";
          5'd7:    w_byte = "T";
          5'd8:    w_byte = "=";
          5'd9:    w_byte = asc(r_tbcd[7:4]);
          5'd10:   w_byte = asc(r_tbcd[3:0]);
          5'd11:   w_byte = ".";
          5'd12:   w_byte = asc(r_tdec);
          default: w_byte = "C";
        endcase
      end
    end else begin
`ifdef FMT_CHECKSUM_EN
      case (w_rel)
        5'd0:    w_byte = "*";
        5'd1:    w_byte = hexc(r_csum[7:4]);
        5'd2:    w_byte = hexc(r_csum[3:0]);
        5'd3:    w_byte = 8'h0D;
        default: w_byte = 8'h0A;
      endcase
`else
      w_byte = (w_rel == 5'd0) ? 8'h0D : 8'h0A;
`endif
    end
  end

  assign tx_push    = (r_state == S_SEND) && !tx_full;
  assign tx_data    = (r_state == S_SEND) ? w_byte : 8'h00;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_FIN);
  assign ovr_cnt    = r_ovr;

endmodule

// File: tb/tb_sensor_uart_formatter.sv
// Directed bench for sensor_uart_formatter: frame contents, latency, priority, overruns, back-pressure, reset.
module tb_sensor_uart_formatter;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] i_dist_data = '0;
  logic          dist_done = 1'b0;
  logic [31:0]   i_dht_data = '0;
  logic          dht_done = 1'b0;
  logic          tx_full = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_push, busy, frame_done;
  logic [7:0]    ovr_cnt;

  sensor_uart_formatter #(.DIST_W(DW), .SAT_INT(99)) dut (
    .clk(clk), .rst(rst),
    .i_dist_data(i_dist_data), .dist_done(dist_done),
    .i_dht_data(i_dht_data), .dht_done(dht_done),
    .tx_full(tx_full), .tx_data(tx_data), .tx_push(tx_push),
    .busy(busy), .frame_done(frame_done), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         done_cyc = -1;
  int         viol = 0;
  logic [7:0] q[$];
  int         push_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if ((dist_done || dht_done) && done_cyc < 0) done_cyc = cyc;
    if (tx_push) begin
      q.push_back(tx_data);
      push_cyc.push_back(cyc);
      if (tx_full) viol++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  typedef struct {
    logic        dd;
    logic        hd;
    logic [9:0]  dv;
    logic [31:0] hv;
    int          nfr;
    int          lat;
    string       exp;
  } vec_t;

  vec_t vecs[8];

  function automatic string fr(input string body);
    string s;
    s = body;
`ifdef FMT_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < body.len(); i++) x = x ^ 8'(body[i]);
      s = {s, $sformatf("*%02X", x)};
    end
`endif
    return {s, "\r\n"};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic setv(input int k, input logic dd, input logic hd, input logic [9:0] dv,
                      input logic [31:0] hv, input int nfr, input int lat, input string exp);
    vecs[k].dd = dd; vecs[k].hd = hd; vecs[k].dv = dv; vecs[k].hv = hv;
    vecs[k].nfr = nfr; vecs[k].lat = lat; vecs[k].exp = exp;
  endtask

  task automatic clear_mon();
    q.delete();
    push_cyc.delete();
    fd_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic pulse(input logic dd, input logic hd, input logic [9:0] dv, input logic [31:0] hv);
    @(posedge clk); #1;
    dist_done = dd; dht_done = hd; i_dist_data = dv; i_dht_data = hv;
    @(posedge clk); #1;
    dist_done = 1'b0; dht_done = 1'b0;
  endtask

  task automatic wait_frames(input string nm, input int n, input int maxc);
    int k;
    k = 0;
    while (fd_cnt < n && k < maxc) begin
      @(posedge clk);
      k++;
    end
    if (fd_cnt < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: frames seen %0d expected %0d", nm, fd_cnt, n);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_bytes(input string nm, input int n, input int maxc);
    int k;
    k = 0;
    while (q.size() < n && k < maxc) begin
      @(posedge clk);
      k++;
    end
    if (q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_bytes_timeout: bytes seen %0d expected %0d", nm, q.size(), n);
    end
  endtask

  task automatic cmp_stream(input string nm, input string exp);
    chk({nm, "_len"}, q.size(), exp.len());
    for (int i = 0; i < exp.len() && i < q.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), int'(q[i]), int'(8'(exp[i])));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_tx_push"}, int'(tx_push), 0);
    chk({nm, "_tx_data"}, int'(tx_data), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_frame_done"}, int'(frame_done), 0);
    chk({nm, "_ovr_cnt"}, int'(ovr_cnt), 0);
  endtask

  initial begin
    int n0;

    setv(0, 1'b1, 1'b0, 10'd123,  32'h0,         1, 12, fr("D=0123"));
    setv(1, 1'b0, 1'b1, 10'd0,    32'h2D00_1705, 1, 10, fr("H=45.0%T=23.5C"));
    setv(2, 1'b0, 1'b1, 10'd0,    32'h7F0C_6400, 1, 10, fr("H=99.9%T=99.0C"));
    setv(3, 1'b1, 1'b1, 10'd400,  32'h3200_1400, 2, 12, {fr("D=0400"), fr("H=50.0%T=20.0C")});
    setv(4, 1'b1, 1'b0, 10'd1023, 32'h0,         1, 12, fr("D=1023"));
    setv(5, 1'b1, 1'b0, 10'd0,    32'h0,         1, 12, fr("D=0000"));
    setv(6, 1'b0, 1'b1, 10'd0,    32'h6309_6309, 1, 10, fr("H=99.9%T=99.9C"));
    setv(7, 1'b0, 1'b1, 10'd0,    32'h640A_0000, 1, 10, fr("H=99.9%T=00.0C"));

    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("por");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 8; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      clear_mon();
      pulse(vecs[v].dd, vecs[v].hd, vecs[v].dv, vecs[v].hv);
      wait_frames(nm, vecs[v].nfr, 300);
      cmp_stream(nm, vecs[v].exp);
      if (push_cyc.size() > 0) begin
        chk({nm, "_latency"}, push_cyc[0] - done_cyc, vecs[v].lat);
        chk({nm, "_fd_gap"}, fd_cyc - push_cyc[push_cyc.size()-1], 1);
      end
    end
    chk("table_ovr_cnt", int'(ovr_cnt), 0);

    // Three distance events during a DHT frame: only the last one survives.
    clear_mon();
    pulse(1'b0, 1'b1, 10'd0, 32'h2D00_1705);
    wait_bytes("mid", 1, 50);
    pulse(1'b1, 1'b0, 10'd100, 32'h0);
    pulse(1'b1, 1'b0, 10'd200, 32'h0);
    pulse(1'b1, 1'b0, 10'd300, 32'h0);
    wait_frames("mid", 2, 300);
    cmp_stream("mid", {fr("H=45.0%T=23.5C"), fr("D=0300")});
    chk("mid_ovr_cnt", int'(ovr_cnt), 2);

    // Back-pressure: held full for 5 cycles, then toggled every cycle.
    clear_mon();
    pulse(1'b1, 1'b0, 10'd456, 32'h0);
    wait_bytes("bp", 2, 50);
    @(posedge clk); #1;
    tx_full = 1'b1;
    n0 = q.size();
    repeat (5) @(posedge clk);
    chk("bp_stall_no_push", q.size(), n0);
    #1;
    tx_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      tx_full = ~tx_full;
    end
    tx_full = 1'b0;
    wait_frames("bp", 1, 100);
    cmp_stream("bp", fr("D=0456"));
    chk("bp_push_while_full", viol, 0);

    // ovr_cnt saturation while the sender is stalled.
    clear_mon();
    pulse(1'b0, 1'b1, 10'd0, 32'h2D00_1705);
    wait_bytes("sat", 1, 50);
    @(posedge clk); #1;
    tx_full = 1'b1;
    dist_done = 1'b1;
    i_dist_data = 10'd777;
    repeat (260) @(posedge clk);
    #1;
    dist_done = 1'b0;
    chk("sat_ovr_cnt", int'(ovr_cnt), 255);
    tx_full = 1'b0;
    wait_frames("sat", 2, 300);
    cmp_stream("sat", {fr("H=45.0%T=23.5C"), fr("D=0777")});
    chk("sat_push_while_full", viol, 0);

    // Reset during SEND byte 3 aborts the frame.
    clear_mon();
    pulse(1'b1, 1'b0, 10'd123, 32'h0);
    wait_bytes("rst", 3, 50);
    #1;
    rst = 1'b1;
    @(posedge clk); #2;
    chk_reset_outputs("rst_mid");
    rst = 1'b0;
    n0 = q.size();
    repeat (30) @(posedge clk);
    chk("rst_no_more_push", q.size(), n0);
    chk("rst_no_frame_done", fd_cnt, 0);
    clear_mon();
    pulse(1'b1, 1'b0, 10'd123, 32'h0);
    wait_frames("post_rst", 1, 100);
    cmp_stream("post_rst", fr("D=0123"));
    if (push_cyc.size() > 0) chk("post_rst_latency", push_cyc[0] - done_cyc, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
